// File: rtl/traffic_intersection_ctrl_if.sv
// rtl/traffic_intersection_ctrl_if.sv - control inputs and lamp/status outputs of the intersection controller
interface traffic_intersection_ctrl_if #(
  parameter int CNT_W = 5
);
  logic             en;
  logic             side_req;
  logic             night_mode;
  logic             a_green;
  logic             a_yellow;
  logic             a_red;
  logic             b_green;
  logic             b_yellow;
  logic             b_red;
  logic [CNT_W-1:0] count;
  logic             sec_tick;
  logic             side_pending;

  // master: the controller itself; slave: whatever drives requests and watches the lamps
  modport master (
    input  en, side_req, night_mode,
    output a_green, a_yellow, a_red, b_green, b_yellow, b_red,
    output count, sec_tick, side_pending
  );

  modport slave (
    output en, side_req, night_mode,
    input  a_green, a_yellow, a_red, b_green, b_yellow, b_red,
    input  count, sec_tick, side_pending
  );
endinterface

// File: rtl/traffic_intersection_ctrl.sv
// rtl/traffic_intersection_ctrl.sv - two-approach intersection controller with all-red clearance, side demand and night flash
module traffic_intersection_ctrl #(
  parameter int CLK_PER_SEC = 50000000,
  parameter int A_GREEN_SEC = 20,
  parameter int B_GREEN_SEC = 10,
  parameter int YELLOW_SEC  = 3,
  parameter int ALL_RED_SEC = 2,
  parameter int CNT_W       = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  traffic_intersection_ctrl_if.master  bus
);

  localparam int               PW         = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_PER_SEC - 1);
  localparam logic [CNT_W-1:0] DUR_AG     = CNT_W'(A_GREEN_SEC);
  localparam logic [CNT_W-1:0] DUR_BG     = CNT_W'(B_GREEN_SEC);
  localparam logic [CNT_W-1:0] DUR_Y      = CNT_W'(YELLOW_SEC);
  localparam logic [CNT_W-1:0] DUR_AR     = CNT_W'(ALL_RED_SEC);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO       = '0;

  typedef enum logic [2:0] {
    S_A_GREEN,
    S_A_YELLOW,
    S_RED_AB,
    S_B_GREEN,
    S_B_YELLOW,
    S_RED_BA,
    S_FLASH
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic [PW-1:0]    presc;
  logic             flash, flash_n;
  logic             pending, pending_n;
  // lamp vector order: a_green, a_yellow, a_red, b_green, b_yellow, b_red
  logic [5:0]       lamp_q, lamp_n;
  logic             tick;

  assign tick = bus.en && (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (bus.en) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_A_GREEN;
      count   <= DUR_AG;
      flash   <= 1'b0;
      pending <= 1'b0;
      lamp_q  <= 6'b100_001;
    end else begin
      state   <= state_n;
      count   <= count_n;
      flash   <= flash_n;
      pending <= pending_n;
      lamp_q  <= lamp_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    flash_n = flash;
    if (tick) begin
      if (state == S_FLASH) begin
        flash_n = ~flash;
        if (!bus.night_mode) begin
          state_n = S_RED_BA;
          count_n = DUR_AR;
        end
      end else if (count > ONE) begin
        count_n = count - ONE;
      end else begin
        case (state)
          S_A_GREEN: begin
            // main road rests on green with count parked at 1 until someone needs the side
            if (pending || bus.night_mode) begin
              state_n = S_A_YELLOW;
              count_n = DUR_Y;
            end
          end
          S_A_YELLOW: begin
            state_n = S_RED_AB;
            count_n = DUR_AR;
          end
          S_RED_AB: begin
            if (bus.night_mode) begin
              state_n = S_FLASH;
              count_n = ZERO;
              flash_n = 1'b1;
            end else begin
              state_n = S_B_GREEN;
              count_n = DUR_BG;
            end
          end
          S_B_GREEN: begin
            state_n = S_B_YELLOW;
            count_n = DUR_Y;
          end
          S_B_YELLOW: begin
            state_n = S_RED_BA;
            count_n = DUR_AR;
          end
          S_RED_BA: begin
            if (bus.night_mode) begin
              state_n = S_FLASH;
              count_n = ZERO;
              flash_n = 1'b1;
            end else begin
              state_n = S_A_GREEN;
              count_n = DUR_AG;
            end
          end
          default: begin
            state_n = S_A_GREEN;
            count_n = DUR_AG;
          end
        endcase
      end
    end

    // entering B_GREEN serves the demand even if a new request arrives on that very edge
    pending_n = pending;
    if (state_n == S_B_GREEN && state != S_B_GREEN) begin
      pending_n = 1'b0;
    end else if (bus.side_req) begin
      pending_n = 1'b1;
    end else if (state == S_FLASH) begin
      pending_n = 1'b0;
    end

    case (state_n)
      S_A_GREEN:  lamp_n = 6'b100_001;
      S_A_YELLOW: lamp_n = 6'b010_001;
      S_RED_AB:   lamp_n = 6'b001_001;
      S_B_GREEN:  lamp_n = 6'b001_100;
      S_B_YELLOW: lamp_n = 6'b001_010;
      S_RED_BA:   lamp_n = 6'b001_001;
      S_FLASH:    lamp_n = {1'b0, flash_n, 1'b0, 1'b0, flash_n, 1'b0};
      default:    lamp_n = 6'b001_001;
    endcase
  end

  assign bus.a_green      = lamp_q[5];
  assign bus.a_yellow     = lamp_q[4];
  assign bus.a_red        = lamp_q[3];
  assign bus.b_green      = lamp_q[2];
  assign bus.b_yellow     = lamp_q[1];
  assign bus.b_red        = lamp_q[0];
  assign bus.count        = count;
  assign bus.sec_tick     = tick;
  assign bus.side_pending = pending;

endmodule

// File: doc/traffic_intersection_ctrl.md
Name: traffic_intersection_ctrl

Overview:
- Parametrised two-approach intersection controller: main road (A) and side road (B).
- Contains its own 1-second prescaler and a per-phase countdown. Adds all-red clearance, demand-driven side phase and a night flashing-yellow mode.
- Drives six lamp outputs and a remaining-seconds value; `count` feeds the existing 7-segment counter decoder unchanged.

Parameters:
- CLK_PER_SEC, 50000000: clk cycles per second tick. Must be ≥2.
- A_GREEN_SEC, 20: minimum green duration, main road.
- B_GREEN_SEC, 10: green duration, side road.
- YELLOW_SEC, 3: yellow duration, both roads.
- ALL_RED_SEC, 2: all-red clearance duration.
- CNT_W, 5: width of `count`. Every duration must be ≥1 and ≤2^CNT_W−1.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: run enable. 0 freezes prescaler, state and count.
- side_req, input, 1: side-road demand (vehicle or pedestrian), level or pulse.
- night_mode, input, 1: 1 requests flashing-yellow operation.
- a_green / a_yellow / a_red, output, 1 each: main-road lamps.
- b_green / b_yellow / b_red, output, 1 each: side-road lamps.
- count, output, CNT_W: seconds remaining in current phase. 0 in FLASH.
- sec_tick, output, 1: one-cycle 1-second pulse.
- side_pending, output, 1: latched side demand.

Behaviour:
- Reset (asynchronous, active-low):
  - state = A_GREEN, count = A_GREEN_SEC, prescaler = 0.
  - side_pending = 0, flash phase = 0, sec_tick = 0.
  - Lamps: a_green = 1, b_red = 1, all others 0.
- Prescaler:
  - While en = 1, increments each cycle and wraps at CLK_PER_SEC−1.
  - sec_tick = 1 in the cycle the prescaler equals CLK_PER_SEC−1 and en = 1. First tick comes CLK_PER_SEC cycles after reset release.
  - en = 0 holds the prescaler and keeps sec_tick at 0.
- State and lamps:
  - All state, count and lamp outputs are registered and updated on the same edge. Lamps are a pure function of state (plus flash phase).
  - Exactly one lamp per road is lit, except in FLASH.
- States and lamps (A lamp / B lamp):
  - A_GREEN: green / red.
  - A_YELLOW: yellow / red.
  - RED_AB: red / red.
  - B_GREEN: red / green.
  - B_YELLOW: red / yellow.
  - RED_BA: red / red.
  - FLASH: both yellows equal the flash phase; all greens and reds 0.
- Phase timing:
  - On entry, count is loaded with the phase duration.
  - On each sec_tick with count > 1, count decrements.
  - On a sec_tick with count == 1 the phase ends: next state is entered and its duration loaded on that same edge. Each phase therefore lasts exactly DUR ticks, and count is never 0 outside FLASH.
- Transitions at phase end:
  - A_GREEN → A_YELLOW only if side_pending or night_mode. Otherwise stay in A_GREEN with count held at 1 and re-evaluate every tick.
  - A_YELLOW → RED_AB.
  - RED_AB → FLASH if night_mode, else B_GREEN.
  - B_GREEN → B_YELLOW.
  - B_YELLOW → RED_BA.
  - RED_BA → FLASH if night_mode, else A_GREEN.
- Night mode:
  - Never cuts a green or yellow short; FLASH is entered only from an all-red phase.
  - In FLASH, every sec_tick toggles the flash phase. Entry to FLASH sets flash phase = 1 (yellows lit immediately).
  - FLASH exit: on a sec_tick with night_mode = 0, go to RED_BA with count = ALL_RED_SEC, then continue to A_GREEN.
- side_pending:
  - Set in any cycle side_req = 1.
  - Cleared on the edge entering B_GREEN, and also while in FLASH.
  - Set has priority over clear, except on the B_GREEN entry edge, where clear wins. A request during B_GREEN/B_YELLOW/RED_BA re-sets it after entry.
- en = 0 mid-phase: everything holds; resuming continues from the held prescaler value.
- Reset mid-operation returns to the reset values immediately, without waiting for a clock edge.

Test Plan:
Common bench settings: CLK_PER_SEC=4, A_GREEN_SEC=5, B_GREEN_SEC=3, YELLOW_SEC=2, ALL_RED_SEC=1, CNT_W=5.
1. Reset, en=1, no requests, 40 cycles → a_green=1, b_red=1 throughout. count 5,4,3,2,1 then stays 1. sec_tick every 4th cycle.
2. side_req pulsed 1 cycle at cycle 6 → side_pending=1. Phase sequence and lengths in cycles:
   - A_GREEN until cycle 20.
   - A_YELLOW 8, RED_AB 4, B_GREEN 12 (side_pending clears at B_GREEN entry).
   - B_YELLOW 8, RED_BA 4, then A_GREEN with count=5.
3. side_req held during A_GREEN count==1 hold → A_YELLOW entered on the very next sec_tick.
4. night_mode=1 raised during B_GREEN → B_GREEN, B_YELLOW and RED_BA complete in full, then FLASH.
   - In FLASH: a_yellow=b_yellow toggling every 4 cycles, count=0.
   - Drop night_mode → RED_BA (count=1), then A_GREEN.
5. en=0 for 10 cycles mid A_YELLOW with count=2 → all outputs and count frozen, sec_tick=0. Resume: the remaining prescaler cycles complete before the next tick.
6. rst_n asserted asynchronously mid B_YELLOW (between edges) → lamps and count return to reset values immediately. Normal sequence restarts after release.
